rf_dump_reader: RTL

- Debug read-side master for the register file's debug port. On a start pulse it walks `reg_sel` from 0 to NREGS-1 and snapshots each `reg_data` word.
- It serialises every snapshot as a byte stream on a valid/ready interface. The stream feeds the board debug path (UART/display bridge).
- It never writes the register file. It is the reader counterpart of the RF write port, so the CPU can keep running during a dump.

---
 rtl/rf_dump_reader_pkg.sv | 42 ++++
 rtl/rf_dump_reader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rf_dump_reader_pkg.sv
// rf_dump_reader_pkg
// Shared definitions for the register-file debug dump reader: the FSM state
// encoding, the number of data bytes per register word, and the byte-lane
// select that maps a byte position within one register's record onto either
// the index header or a big-endian slice of the captured word.
package rf_dump_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam int DATA_BYTES = 4;

  // Byte position 0 is the index header when headers are enabled; the data
  // bytes then follow most-significant first, so the slice index is the
  // position with the header slot removed.
  function automatic logic [7:0] byte_lane(input logic [2:0]  byteCnt,
                                           input logic [31:0] snapshot,
                                           input logic [7:0]  idx,
                                           input logic        hdrEn);
    logic [2:0] dataPos;
    logic [7:0] laneByte;
    laneByte = '0;
    dataPos  = byteCnt - {2'b00, hdrEn};
    if (hdrEn && (byteCnt == 3'd0)) begin
      laneByte = idx;
    end else begin
      case (dataPos)
        3'd0:    laneByte = snapshot[31:24];
        3'd1:    laneByte = snapshot[23:16];
        3'd2:    laneByte = snapshot[15:8];
        3'd3:    laneByte = snapshot[7:0];
        default: laneByte = '0;
      endcase
    end
    return laneByte;
  endfunction

endpackage

// File: rtl/rf_dump_reader.sv
// rf_dump_reader
// Read-only debug master for the register file's debug port. A start pulse
// in IDLE walks reg_sel over every register, captures each word in its own
// LOAD cycle and streams it out as bytes on a valid/ready interface (an
// optional index header byte first, then the word big-endian).
//
// Ports
//   clk       system clock, rising edge
//   clrn      asynchronous active-low reset
//   start     one-cycle dump request, honoured only in IDLE
//   reg_sel   register index presented to the RF debug port
//   reg_data  RF debug read data for reg_sel (combinational in the RF)
//   tx_data   stream byte
//   tx_valid  tx_data is valid
//   tx_ready  sink accepts the byte on a rising edge with tx_valid high
//   busy      high from the first LOAD through the DONE cycle
//   done      one-cycle pulse when the whole dump has been sent
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int IDX_W  = 5,
  parameter int HDR_EN = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  output logic [IDX_W-1:0] reg_sel,
  input  logic [31:0]      reg_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam int               BYTES     = DATA_BYTES + HDR_EN;
  localparam logic [2:0]       LAST_BYTE = 3'(BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREGS - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_idx;
  logic [2:0]       r_byteCnt;
  logic [31:0]      r_snapshot;
  logic             w_accept;
  logic             w_lastByte;
  logic             w_lastReg;

  assign w_accept   = (r_state == ST_SEND) && tx_ready;
  assign w_lastByte = (r_byteCnt == LAST_BYTE);
  assign w_lastReg  = (r_idx == LAST_IDX);
  assign reg_sel    = r_idx;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // All stream outputs are decoded from registered state only, so tx_ready
  // never reaches tx_data or tx_valid combinationally and a stalled byte
  // stays put until it is accepted.
  always_comb begin
    w_nextState = r_state;
    tx_valid    = 1'b0;
    tx_data     = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy        = 1'b1;
        w_nextState = ST_SEND;
      end
      ST_SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = byte_lane(r_byteCnt, r_snapshot, 8'(r_idx), (HDR_EN != 0));
        if (w_accept && w_lastByte) begin
          w_nextState = w_lastReg ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // The word is captured only in LOAD, so RF writes after that edge do not
  // disturb the record being streamed while the CPU keeps running.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_idx      <= '0;
      r_byteCnt  <= '0;
      r_snapshot <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_snapshot <= reg_data;
          r_byteCnt  <= '0;
        end
        ST_SEND: begin
          if (w_accept) begin
            if (w_lastByte) begin
              r_byteCnt <= '0;
              if (!w_lastReg) begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end else begin
              r_byteCnt <= r_byteCnt + 3'd1;
            end
          end
        end
        ST_DONE: begin
          r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
